ucsbece154_imem_burst_responder: RTL and testbench
==================================================

# ucsbece154_imem_burst_responder

Memory-side responder for the instruction-cache refill interface. It accepts a block read request from the I-cache, waits a programmable access latency, then returns the addressed block as a burst of `BLOCK_WORDS` consecutive words, one per cycle, from an internal word-addressed backing store. It stands in for the SDRAM controller in simulation and FPGA builds. A side load port preloads program images.

## Interface
- `BLOCK_WORDS`, 4: words per block and per burst; power of two, ≥ 2.
- `WORD_SIZE`, 32: data width.
- `MEM_WORDS`, 1024: backing-store depth in words; power of two.
- `LATENCY`, 10: cycles from request acceptance to first data word; ≥ 1.

- `Clk` input 1: single clock; all state updates on the rising edge.
- `Reset` input 1: synchronous, active-low; low at a rising edge resets the block.
- `MemReadRequest` input 1: level request from the cache, held until the burst ends.
- `MemReadAddress` input 32: byte address of the requested word, any word in the block.
- `MemDataIn` output `WORD_SIZE`: burst data word; 0 whenever `MemDataReady` is low.
- `MemDataReady` output 1: qualifies `MemDataIn` for one cycle per word.
- `LoadEnable` input 1: writes the backing store.
- `LoadAddress` input 32: byte address of the load word; bits [1:0] ignored.
- `LoadData` input `WORD_SIZE`: load data.

## Operation
- Reset (`Reset`=0 at an edge) drives `MemDataIn`=0, `MemDataReady`=0, state IDLE, and clears all counters. Backing-store contents are not cleared.
- Word index is `addr[$clog2(MEM_WORDS)+1:2]`. Upper address bits are discarded, so accesses wrap modulo `MEM_WORDS`.
- Block base: the word index with its low `$clog2(BLOCK_WORDS)` bits zeroed. The burst always returns words in order base+0 … base+`BLOCK_WORDS`-1, never critical-word-first.
- States:
  - IDLE: if `MemReadRequest`=1, latch the base index from `MemReadAddress` and load the latency counter. Go to WAIT, or directly to BURST when `LATENCY`=1.
  - WAIT: count down `LATENCY`-1 cycles, then go to BURST.
  - BURST: assert `MemDataReady` with `MemDataIn`=mem[base+k] for k = 0 … `BLOCK_WORDS`-1 on consecutive cycles. After the last word, go to DONE.
  - DONE: outputs 0. Go to IDLE on the first cycle `MemReadRequest`=0.
- Abort: `MemReadRequest`=0 in WAIT or BURST sends the block to IDLE at that edge; `MemDataReady` is 0 from the next cycle. A later request starts a fresh burst at word 0.
- `MemReadAddress` changes after acceptance are ignored until the next IDLE acceptance.
- Load port: `LoadEnable`=1 writes mem[index(`LoadAddress`)] at the edge, in any state. A load to the word being output in the same cycle does not affect that cycle's `MemDataIn` (read-before-write). Words output later see the new value.
- Loads during reset are honoured.
- Burst counter width is `$clog2(BLOCK_WORDS)`. The latency counter width is `$clog2(LATENCY+1)`.

## Timing
- Request sampled high in IDLE at edge t: first `MemDataReady`=1 in the cycle following edge t+`LATENCY`-1. Word k is valid in cycle t+`LATENCY`+k, counted in cycles after edge t.
- `MemDataReady` is high exactly `BLOCK_WORDS` consecutive cycles per unaborted request, with no gaps.
- The minimum request-to-request spacing is one cycle with `MemReadRequest` low. A request held high after the burst never triggers a second burst.
- All outputs are registered; no combinational path from any input to any output.

## Test plan
- Reset: hold `Reset`=0 for 3 cycles with `MemReadRequest`=1 → `MemDataReady`=0 and `MemDataIn`=0 throughout. After release, the burst starts exactly `LATENCY` cycles after the first sampling edge.
- Basic burst: preload word indices 0x40–0x43 with 0xA0000000–0xA0000003, `LATENCY`=10, request address 0x108 at edge t → `MemDataReady` high in cycles t+10 … t+13 with data 0xA0000000, …01, …02, …03. `MemDataReady` low at t+14.
- Wrap: `MEM_WORDS`=1024, address 0x1000 → returns mem[0..3]. With `LATENCY`=1, the first word appears in the cycle after acceptance.
- Abort and re-request: drop `MemReadRequest` after the second word → `MemDataReady` low next cycle. Re-raise with address 0x200 → a full four-word burst from index 0x80 after `LATENCY`.
- Held request and mid-burst reset: keep `MemReadRequest` high after the burst → no further `MemDataReady` until it drops for one cycle. Assert `Reset`=0 during word 1 → outputs 0 at the next edge, state IDLE.
- Load collision: `LoadEnable` writes 0xDEADBEEF to base+1 in the cycle word 1 is output → old value returned. A repeat request returns 0xDEADBEEF for word 1.

Source files
------------

// File: rtl/ucsbece154_imem_burst_responder.sv
// I-cache refill responder: after a fixed access latency, returns the requested
// block from a word-addressed backing store as an in-order burst.
module ucsbece154_imem_burst_responder #(
  parameter int BLOCK_WORDS = 4,
  parameter int WORD_SIZE   = 32,
  parameter int MEM_WORDS   = 1024,
  parameter int LATENCY     = 10
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 MemReadRequest,
  input  logic [31:0]          MemReadAddress,
  output logic [WORD_SIZE-1:0] MemDataIn,
  output logic                 MemDataReady,
  input  logic                 LoadEnable,
  input  logic [31:0]          LoadAddress,
  input  logic [WORD_SIZE-1:0] LoadData
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int BB = $clog2(BLOCK_WORDS);
  localparam int LW = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {IDLE, WAIT, BURST, DONE} state_t;

  state_t               state;
  logic [AW-BB-1:0]     base_hi;
  logic [BB-1:0]        beat;
  logic [LW-1:0]        lat_cnt;
  logic [WORD_SIZE-1:0] mem [MEM_WORDS];

  logic [AW-BB-1:0] req_hi;
  logic [AW-1:0]    load_idx;
  logic [BB-1:0]    next_beat;
  logic             unused_addr_bits;

  assign req_hi    = MemReadAddress[AW+1:BB+2];
  assign load_idx  = LoadAddress[AW+1:2];
  assign next_beat = beat + 1'b1;
  assign unused_addr_bits = ^{MemReadAddress[31:AW+2], MemReadAddress[BB+1:0],
                              LoadAddress[31:AW+2], LoadAddress[1:0]};

  // Backing store is never reset, so loads during reset still land.
  always_ff @(posedge Clk) begin
    if (LoadEnable) mem[load_idx] <= LoadData;
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state        <= IDLE;
      MemDataReady <= 1'b0;
      MemDataIn    <= '0;
      base_hi      <= '0;
      beat         <= '0;
      lat_cnt      <= '0;
    end else begin
      MemDataReady <= 1'b0;
      MemDataIn    <= '0;
      case (state)
        IDLE: begin
          if (MemReadRequest) begin
            base_hi <= req_hi;
            beat    <= '0;
            lat_cnt <= LW'(LATENCY - 1);
            if (LATENCY == 1) begin
              MemDataReady <= 1'b1;
              MemDataIn    <= mem[{req_hi, {BB{1'b0}}}];
              state        <= BURST;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (!MemReadRequest) begin
            state <= IDLE;
          end else if (lat_cnt == LW'(1)) begin
            // Word 0 is registered on the last wait edge so it is valid LATENCY cycles after acceptance.
            MemDataReady <= 1'b1;
            MemDataIn    <= mem[{base_hi, {BB{1'b0}}}];
            state        <= BURST;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        BURST: begin
          if (!MemReadRequest) begin
            state <= IDLE;
          end else if (beat == BB'(BLOCK_WORDS - 1)) begin
            state <= DONE;
          end else begin
            beat         <= next_beat;
            MemDataReady <= 1'b1;
            MemDataIn    <= mem[{base_hi, next_beat}];
          end
        end
        DONE: begin
          if (!MemReadRequest) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ucsbece154_imem_burst_responder.sv
// Directed bench for the I-cache burst responder: a LATENCY=10 instance for the
// main scenarios and a LATENCY=1 instance for the wrap/minimum-latency case.
module tb_ucsbece154_imem_burst_responder;

  localparam int LAT = 10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, req1;
  logic [31:0] addr, addr1;
  logic [31:0] data, data1;
  logic        ready, ready1;
  logic        load_en;
  logic [31:0] load_addr, load_data;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ucsbece154_imem_burst_responder #(
    .BLOCK_WORDS(4), .WORD_SIZE(32), .MEM_WORDS(1024), .LATENCY(LAT)
  ) dut (
    .Clk(clk), .Reset(rst_n), .MemReadRequest(req), .MemReadAddress(addr),
    .MemDataIn(data), .MemDataReady(ready), .LoadEnable(load_en),
    .LoadAddress(load_addr), .LoadData(load_data)
  );

  ucsbece154_imem_burst_responder #(
    .BLOCK_WORDS(4), .WORD_SIZE(32), .MEM_WORDS(1024), .LATENCY(1)
  ) dut1 (
    .Clk(clk), .Reset(rst_n), .MemReadRequest(req1), .MemReadAddress(addr1),
    .MemDataIn(data1), .MemDataReady(ready1), .LoadEnable(load_en),
    .LoadAddress(load_addr), .LoadData(load_data)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] la [12];
    logic [31:0] ld [12];
    for (int i = 0; i < 4; i++) begin
      la[i]   = 32'h100 + 4*i;  ld[i]   = 32'hA000_0000 + i;
      la[i+4] = 32'h200 + 4*i;  ld[i+4] = 32'hC000_0000 + i;
      la[i+8] = 32'h000 + 4*i;  ld[i+8] = 32'hB000_0000 + i;
    end
    rst_n = 1'b0; req = 1'b1; addr = 32'h104;
    for (int i = 0; i < 12; i++) begin
      load_en = 1'b1; load_addr = la[i]; load_data = ld[i];
      step();
      checks++;
      if (ready !== 1'b0 || data !== 32'h0) begin
        errors++;
        $display("FAIL reset_hold[%0d] ready=%b data=%h required ready=0 data=0", i, ready, data);
      end
    end
    load_en = 1'b0;
    rst_n = 1'b1;
    for (int j = 0; j < LAT - 1; j++) begin
      step();
      checks++;
      if (ready !== 1'b0) begin
        errors++;
        $display("FAIL reset_release_wait[%0d] ready=%b required 0", j, ready);
      end
    end
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if (ready !== 1'b1 || data !== 32'hA000_0000 + k) begin
        errors++;
        $display("FAIL reset_release_word%0d ready=%b data=%h required ready=1 data=%h",
                 k, ready, data, 32'hA000_0000 + k);
      end
    end
    step();
    checks++;
    if (ready !== 1'b0 || data !== 32'h0) begin
      errors++;
      $display("FAIL reset_release_end ready=%b data=%h required ready=0 data=0", ready, data);
    end
    req = 1'b0;
    step();
  endtask

  task automatic test_basic_burst();
    req = 1'b1; addr = 32'h108;
    for (int j = 0; j < LAT - 1; j++) begin
      step();
      if (j == 0) addr = 32'h200;  // must be ignored after acceptance
      checks++;
      if (ready !== 1'b0 || data !== 32'h0) begin
        errors++;
        $display("FAIL basic_wait[%0d] ready=%b data=%h required ready=0 data=0", j, ready, data);
      end
    end
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if (ready !== 1'b1 || data !== 32'hA000_0000 + k) begin
        errors++;
        $display("FAIL basic_word%0d ready=%b data=%h required ready=1 data=%h",
                 k, ready, data, 32'hA000_0000 + k);
      end
    end
    step();
    checks++;
    if (ready !== 1'b0 || data !== 32'h0) begin
      errors++;
      $display("FAIL basic_end ready=%b data=%h required ready=0 data=0", ready, data);
    end
    req = 1'b0;
    step();
  endtask

  task automatic test_wrap();
    checks++;
    if (ready1 !== 1'b0) begin
      errors++;
      $display("FAIL wrap_idle ready=%b required 0", ready1);
    end
    req1 = 1'b1; addr1 = 32'h1000;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if (ready1 !== 1'b1 || data1 !== 32'hB000_0000 + k) begin
        errors++;
        $display("FAIL wrap_word%0d ready=%b data=%h required ready=1 data=%h",
                 k, ready1, data1, 32'hB000_0000 + k);
      end
    end
    step();
    checks++;
    if (ready1 !== 1'b0 || data1 !== 32'h0) begin
      errors++;
      $display("FAIL wrap_end ready=%b data=%h required ready=0 data=0", ready1, data1);
    end
    req1 = 1'b0;
    step();
  endtask

  task automatic test_abort();
    req = 1'b1; addr = 32'h108;
    repeat (LAT - 1) step();
    for (int k = 0; k < 2; k++) begin
      step();
      checks++;
      if (ready !== 1'b1 || data !== 32'hA000_0000 + k) begin
        errors++;
        $display("FAIL abort_word%0d ready=%b data=%h required ready=1 data=%h",
                 k, ready, data, 32'hA000_0000 + k);
      end
    end
    req = 1'b0;
    step();
    checks++;
    if (ready !== 1'b0 || data !== 32'h0) begin
      errors++;
      $display("FAIL abort_drop ready=%b data=%h required ready=0 data=0", ready, data);
    end
    req = 1'b1; addr = 32'h200;
    for (int j = 0; j < LAT - 1; j++) begin
      step();
      checks++;
      if (ready !== 1'b0) begin
        errors++;
        $display("FAIL rereq_wait[%0d] ready=%b required 0", j, ready);
      end
    end
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if (ready !== 1'b1 || data !== 32'hC000_0000 + k) begin
        errors++;
        $display("FAIL rereq_word%0d ready=%b data=%h required ready=1 data=%h",
                 k, ready, data, 32'hC000_0000 + k);
      end
    end
    req = 1'b0;
    step();
    step();
  endtask

  task automatic test_held_request();
    req = 1'b1; addr = 32'h200;
    repeat (LAT + 3) step();
    checks++;
    if (ready !== 1'b1 || data !== 32'hC000_0003) begin
      errors++;
      $display("FAIL held_last_word ready=%b data=%h required ready=1 data=c0000003", ready, data);
    end
    for (int j = 0; j < 6; j++) begin
      step();
      checks++;
      if (ready !== 1'b0 || data !== 32'h0) begin
        errors++;
        $display("FAIL held_no_rearm[%0d] ready=%b data=%h required ready=0 data=0", j, ready, data);
      end
    end
    req = 1'b0;
    step();
    req = 1'b1; addr = 32'h108;
    repeat (LAT) step();
    step();
    checks++;
    if (ready !== 1'b1 || data !== 32'hA000_0001) begin
      errors++;
      $display("FAIL held_rearm_word1 ready=%b data=%h required ready=1 data=a0000001", ready, data);
    end
    rst_n = 1'b0;
    step();
    checks++;
    if (ready !== 1'b0 || data !== 32'h0) begin
      errors++;
      $display("FAIL midburst_reset ready=%b data=%h required ready=0 data=0", ready, data);
    end
    rst_n = 1'b1;
    for (int j = 0; j < LAT - 1; j++) begin
      step();
      checks++;
      if (ready !== 1'b0) begin
        errors++;
        $display("FAIL post_reset_wait[%0d] ready=%b required 0", j, ready);
      end
    end
    step();
    checks++;
    if (ready !== 1'b1 || data !== 32'hA000_0000) begin
      errors++;
      $display("FAIL post_reset_word0 ready=%b data=%h required ready=1 data=a0000000", ready, data);
    end
    req = 1'b0;
    step();
    step();
  endtask

  task automatic test_load_collision();
    logic [31:0] exp2 [4];
    exp2[0] = 32'hA000_0000; exp2[1] = 32'hDEAD_BEEF;
    exp2[2] = 32'hA000_0002; exp2[3] = 32'hA000_0003;
    req = 1'b1; addr = 32'h108;
    repeat (LAT) step();
    step();
    load_en = 1'b1; load_addr = 32'h104; load_data = 32'hDEAD_BEEF;
    checks++;
    if (ready !== 1'b1 || data !== 32'hA000_0001) begin
      errors++;
      $display("FAIL collide_word1 ready=%b data=%h required ready=1 data=a0000001", ready, data);
    end
    step();
    load_en = 1'b0;
    checks++;
    if (ready !== 1'b1 || data !== 32'hA000_0002) begin
      errors++;
      $display("FAIL collide_word2 ready=%b data=%h required ready=1 data=a0000002", ready, data);
    end
    step();
    step();
    req = 1'b0;
    step();
    req = 1'b1;
    repeat (LAT - 1) step();
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if (ready !== 1'b1 || data !== exp2[k]) begin
        errors++;
        $display("FAIL reload_word%0d ready=%b data=%h required ready=1 data=%h",
                 k, ready, data, exp2[k]);
      end
    end
    step();
    checks++;
    if (ready !== 1'b0 || data !== 32'h0) begin
      errors++;
      $display("FAIL reload_end ready=%b data=%h required ready=0 data=0", ready, data);
    end
    req = 1'b0;
    step();
  endtask

  initial begin
    rst_n = 1'b0; req = 1'b0; addr = '0; req1 = 1'b0; addr1 = '0;
    load_en = 1'b0; load_addr = '0; load_data = '0;
    step();
    test_reset();
    test_basic_burst();
    test_wrap();
    test_abort();
    test_held_request();
    test_load_collision();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
